// File: rtl/move_buttons_pkg.sv
// move_buttons_pkg: register map, readdata field positions and debouncer state type
package move_buttons_pkg;
   localparam int N_BUTTONS = 4;
   localparam logic [1:0] REG_LEVEL = 2'd0;
   localparam logic [1:0] REG_EDGE  = 2'd1;
   localparam logic [1:0] REG_MASK  = 2'd2;
   localparam logic [1:0] REG_FIFO  = 2'd3;
   localparam int RD_VALID_BIT  = 8;
   localparam int RD_OCC_LSB    = 12;
   localparam int RD_OCC_W      = 4;
   localparam int RD_OVF_BIT    = 16;
   localparam int MASK_FIFO_BIT = 4;
   typedef enum logic {STABLE, COUNT} db_state_t;
endpackage

// File: rtl/move_buttons_ctrl_if.sv
// move_buttons_ctrl_if: Avalon-MM slave bus plus interrupt line
interface move_buttons_ctrl_if;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   modport master(output address, read, write, writedata, input readdata, irq);
   modport slave(input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser, optional inversion and debounce FSM for one button
module button_debounce
   import move_buttons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync;
   logic synced, level_d, level_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   db_state_t state, state_nxt;
   assign synced = sync[1] ^ ACTIVE_LOW;
   // synchroniser resets to the idle pin level so reset release is not seen as a press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync    <= {2{ACTIVE_LOW}};
         state   <= STABLE;
         cnt     <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
      end else begin
         sync    <= {sync[0], pin};
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         level   <= level_nxt;
         level_d <= level;
      end
   end
   // entering COUNT already counts the first differing cycle
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      level_nxt = level;
      if (state == STABLE) begin
         if (synced != level) begin
            state_nxt = COUNT;
            cnt_nxt   = CW'(1);
         end
      end else if (synced == level) begin
         state_nxt = STABLE;
      end else if (cnt == LAST) begin
         state_nxt = STABLE;
         level_nxt = synced;
      end else begin
         cnt_nxt = cnt + CW'(1);
      end
   end
   always_comb press = level & ~level_d;
endmodule

// File: rtl/move_buttons_ctrl.sv
// move_buttons_ctrl: debounced button register file with W1C edge capture, press-event FIFO and IRQ
module move_buttons_ctrl
   import move_buttons_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_BUTTONS-1:0] in_port,
   move_buttons_ctrl_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [N_BUTTONS-1:0] level, press, edge_cap, w1c;
   logic [N_BUTTONS:0]   mask;
   logic [N_BUTTONS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic overflow, rd_fifo, push, pop, push_ok, ovf_set, nonempty, full;
   logic [31:0] rdata;
   logic unused;
   assign unused = ^bus.writedata[31:N_BUTTONS+1];
   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_db (
         .clk(clk), .reset_n(reset_n), .pin(in_port[i]), .level(level[i]), .press(press[i])
      );
   end
   always_comb begin
      w1c      = (bus.write && bus.address == REG_EDGE) ? bus.writedata[N_BUTTONS-1:0] : '0;
      rd_fifo  = bus.read && bus.address == REG_FIFO;
      nonempty = count != '0;
      full     = count == CW'(FIFO_DEPTH);
      push     = |press;
      pop      = rd_fifo && nonempty;
      push_ok  = push && (!full || pop);
      ovf_set  = push && full && !pop;
   end
   always_comb begin
      rdata = '0;
      case (bus.address)
         REG_LEVEL: rdata[N_BUTTONS-1:0] = level;
         REG_EDGE:  rdata[N_BUTTONS-1:0] = edge_cap;
         REG_MASK:  rdata[N_BUTTONS:0]   = mask;
         default: begin
            rdata[N_BUTTONS-1:0]             = nonempty ? fifo_mem[rd_ptr] : '0;
            rdata[RD_VALID_BIT]              = nonempty;
            rdata[RD_OCC_LSB +: RD_OCC_W]    = RD_OCC_W'(count);
            rdata[RD_OVF_BIT]                = overflow;
         end
      endcase
   end
   always_ff @(posedge clk) if (push_ok) fifo_mem[wr_ptr] <= press;
   // set beats W1C on edge bits and beats read-clear on overflow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_cap     <= '0;
         mask         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         edge_cap <= (edge_cap & ~w1c) | press;
         if (bus.write && bus.address == REG_MASK) mask <= bus.writedata[N_BUTTONS:0];
         if (bus.read) bus.readdata <= rdata;
         bus.irq  <= |(edge_cap & mask[N_BUTTONS-1:0]) | (mask[MASK_FIFO_BIT] & nonempty);
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count    <= count + CW'(push_ok) - CW'(pop);
         overflow <= ovf_set | (overflow & ~rd_fifo);
      end
   end
endmodule

// File: tb/tb_move_buttons_ctrl.sv
// tb_move_buttons_ctrl: directed scenario tests for move_buttons_ctrl with DEBOUNCE_CYCLES=4
module tb_move_buttons_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [3:0] in_port = 4'hF;
   logic [31:0] rd;
   int checks = 0;
   int errors = 0;
   move_buttons_ctrl_if bus();
   move_buttons_ctrl #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus.slave)
   );
   always #5 clk = ~clk;

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a;
      bus.read = 1'b1;
      @(posedge clk);
      #1 bus.read = 1'b0;
      d = bus.readdata;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address = a;
      bus.writedata = d;
      bus.write = 1'b1;
      @(posedge clk);
      #1 bus.write = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0); end
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
      @(negedge clk) reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         do_read(2'(a), rd);
         checks++;
         if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, rd, 32'h0); end
      end
   endtask

   task automatic test_single_press;
      @(negedge clk) in_port = 4'b1110;
      repeat (5) @(posedge clk);
      do_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL level_before_6: got %h expected %h", rd, 32'h0); end
      do_read(2'd0, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL level_at_6: got %h expected %h", rd, 32'h1); end
      do_read(2'd1, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL edge_single: got %h expected %h", rd, 32'h1); end
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0000_1101) begin errors++; $display("FAIL fifo_single: got %h expected %h", rd, 32'h0000_1101); end
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", bus.irq); end
      @(negedge clk) in_port = 4'hF;
      repeat (12) @(posedge clk);
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL release_no_event: got %h expected %h", rd, 32'h0); end
      do_write(2'd1, 32'hF);
      do_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL edge_w1c: got %h expected %h", rd, 32'h0); end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk) in_port = (i % 2 == 0) ? 4'b1101 : 4'hF;
         @(negedge clk);
      end
      repeat (10) @(posedge clk);
      do_read(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL bounce_level: got %h expected %h", rd, 32'h0); end
      do_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL bounce_edge: got %h expected %h", rd, 32'h0); end
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL bounce_fifo: got %h expected %h", rd, 32'h0); end
   endtask

   task automatic test_irq;
      do_write(2'd2, 32'h1);
      @(negedge clk) in_port = 4'b1110;
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_rise_plus1: got %b expected 0", bus.irq); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_rise_plus2: got %b expected 1", bus.irq); end
      do_write(2'd1, 32'h1);
      @(posedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", bus.irq); end
      @(negedge clk) in_port = 4'hF;
      repeat (12) @(posedge clk);
      @(negedge clk) in_port = 4'b1110;
      repeat (6) @(posedge clk);
      do_write(2'd1, 32'h1);
      do_read(2'd1, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL set_beats_w1c: got %h expected %h", rd, 32'h1); end
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set_beats_w1c: got %b expected 1", bus.irq); end
      @(negedge clk) in_port = 4'hF;
      repeat (12) @(posedge clk);
      do_write(2'd1, 32'hF);
      do_write(2'd2, 32'h0);
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0000_2101) begin errors++; $display("FAIL irq_fifo_pop1: got %h expected %h", rd, 32'h0000_2101); end
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0000_1101) begin errors++; $display("FAIL irq_fifo_pop2: got %h expected %h", rd, 32'h0000_1101); end
   endtask

   task automatic test_simultaneous;
      @(negedge clk) in_port = 4'b0011;
      repeat (12) @(posedge clk);
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0000_110C) begin errors++; $display("FAIL simul_entry: got %h expected %h", rd, 32'h0000_110C); end
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL simul_single: got %h expected %h", rd, 32'h0); end
      do_read(2'd0, rd);
      checks++;
      if (rd !== 32'hC) begin errors++; $display("FAIL simul_level: got %h expected %h", rd, 32'hC); end
      @(negedge clk) in_port = 4'hF;
      repeat (12) @(posedge clk);
      do_write(2'd1, 32'hF);
   endtask

   task automatic test_overflow;
      logic [31:0] exp;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk) in_port = ~(4'b0001 << (i % 4));
         repeat (10) @(posedge clk);
         @(negedge clk) in_port = 4'hF;
         repeat (10) @(posedge clk);
      end
      for (int k = 0; k < 8; k++) begin
         exp = 32'h100 | (32'(8 - k) << 12) | (32'(k == 0) << 16) | (32'h1 << (k % 4));
         do_read(2'd3, rd);
         checks++;
         if (rd !== exp) begin errors++; $display("FAIL ovf_pop%0d: got %h expected %h", k, rd, exp); end
      end
      do_read(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL ovf_ninth_absent: got %h expected %h", rd, 32'h0); end
      do_write(2'd1, 32'hF);
      do_read(2'd1, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL ovf_edge_clear: got %h expected %h", rd, 32'h0); end
   endtask

   task automatic test_reset_mid;
      do_write(2'd2, 32'h10);
      @(negedge clk) in_port = 4'b1110;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bus.irq !== 1'b1) begin errors++; $display("FAIL fifo_irq: got %b expected 1", bus.irq); end
      do_read(2'd0, rd);
      checks++;
      if (rd !== 32'h1) begin errors++; $display("FAIL pre_reset_level: got %h expected %h", rd, 32'h1); end
      @(negedge clk) in_port = 4'b1100;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.readdata !== 32'h0) begin errors++; $display("FAIL async_reset_readdata: got %h expected %h", bus.readdata, 32'h0); end
      checks++;
      if (bus.irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", bus.irq); end
      in_port = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (10) @(posedge clk);
      for (int a = 0; a < 4; a++) begin
         do_read(2'(a), rd);
         checks++;
         if (rd !== 32'h0) begin errors++; $display("FAIL post_reset_reg%0d: got %h expected %h", a, rd, 32'h0); end
      end
   endtask

   initial begin
      bus.address = 2'd0;
      bus.read = 1'b0;
      bus.write = 1'b0;
      bus.writedata = 32'h0;
      test_reset;
      test_single_press;
      test_bounce;
      test_irq;
      test_simultaneous;
      test_overflow;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/move_buttons_ctrl.md
# move_buttons_ctrl

Avalon-MM slave controller for the four robot-movement push-buttons. Synchronises and debounces each button, captures press events into a write-1-to-clear register, queues press events in order in a small FIFO, and raises a maskable interrupt. The Nios II software uses it as the direction-command source for the AR robot game, in place of polling raw button levels.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000 (1 ms at 50 MHz): stable cycles required before the debounced level changes; must be ≥2.
- `ACTIVE_LOW`, default 1: when 1, `in_port` is inverted after synchronisation, so pressed = 1 internally.
- `FIFO_DEPTH`, default 8: press-event FIFO entries; must be a power of 2.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: register select.
- `read` in 1: read strobe.
- `write` in 1: write strobe.
- `writedata` in 32: write data.
- `in_port` in 4: raw button pins, asynchronous.
- `readdata` out 32: registered read data; reset value 0.
- `irq` out 1: registered interrupt, level, active-high; reset value 0.

## Operation
- **Input path.** 2-FF synchroniser per bit, then optional inversion, then per-button debouncer.
- **Debouncer.** Two states:
  - STABLE: counter = 0. When the synced level differs from the debounced level, go to COUNT.
  - COUNT: counter increments each cycle. If the synced level returns equal to the debounced level, clear the counter and go to STABLE. When counter = DEBOUNCE_CYCLES−1 and the level still differs, toggle the debounced level, clear the counter and go to STABLE.
- **Press event.** A 0→1 transition of a debounced bit. Releases generate no events.
- **Register map (0x0 to 0x3, word address):**
  - 0x0, R: `[3:0]` debounced levels. Writes are ignored.
  - 0x1, R/W: edge capture `[3:0]`. A press sets its bit. A write clears each bit where `writedata` is 1 (W1C).
  - 0x2, R/W: IRQ mask `[3:0]` (reset 0); bit 4 is the FIFO-nonempty IRQ enable (reset 0).
  - 0x3, R: FIFO pop. Fields:
    - `[3:0]` event mask (all buttons pressed in that cycle).
    - `[8]` valid.
    - `[15:12]` occupancy before the pop.
    - `[16]` sticky overflow flag.
  - Reading 0x3 when nonempty pops one entry. Every read of 0x3 clears overflow. Writes to 0x3 are ignored.
- **FIFO push.** One entry per cycle in which any press occurs. The entry holds the OR of all simultaneous presses, so simultaneous presses form one entry.
- **irq.** `irq = |(edge & mask[3:0]) | (mask[4] & fifo_nonempty)`.
- **readdata.** Unused bits are 0. Reads of unlisted fields return 0.

## Timing
- Read latency is 1 cycle: `readdata` is valid on the cycle after `read` is asserted, matching the existing PIO slaves. `readdata` holds its value until the next read.
- Pin change to debounced level update: 2 + DEBOUNCE_CYCLES cycles when the pin is held stable.
- Debounced rise to edge-capture bit and FIFO entry: +1 cycle. To `irq`: +2 cycles.
- Set and W1C on the same bit in the same cycle: set wins.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When full, this is not an overflow; the pushed entry is accepted.
- Push while full with no pop: entry dropped and overflow set. Existing contents are unchanged.
- Pop while empty: returns valid = 0 and mask = 0, with no pointer change.
- Overflow set and clear in the same cycle: set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count.
- Reset (asynchronous, any time) clears:
  - synchronisers, debounced levels and counters;
  - edge register, mask, FIFO pointers and count, and overflow;
  - `readdata` and `irq`.
- After reset, a button already held produces an event once it has debounced.

## Structure
- Package `move_buttons_pkg` holds:
  - register address constants `REG_LEVEL`, `REG_EDGE`, `REG_MASK`, `REG_FIFO`;
  - the button count (4);
  - readdata field bit positions;
  - the debouncer state typedef `{STABLE, COUNT}`.
- Sub-module `button_debounce`: one instance per button via generate. It contains the synchroniser, the debounce FSM and counter, and outputs `level` and a `press` pulse.
- The top level holds the register file, the FIFO (inline circular buffer) and the IRQ logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `ACTIVE_LOW=1`.
- Hold `in_port=4'b1110` stable → after 6 cycles, reg 0x0 reads 0x1; reg 0x1 reads 0x1; reg 0x3 reads valid = 1, mask = 0x1, occupancy = 1.
- Toggle bit 1 every 2 cycles for 40 cycles → debounced level stays 0, no edge bit set, FIFO empty.
- Mask = 0x1; press button 0 → `irq`=1 two cycles after the debounced rise. Write 0x1 to reg 0x1 → `irq`=0 next cycle. Repeat with W1C in the same cycle as a new press → bit stays 1.
- Press buttons 2 and 3 in the same cycle → single FIFO entry with mask 0xC.
- Generate 9 distinct presses with no reads → 8 entries. First 0x3 read returns occupancy = 8 and overflow = 1; the second returns overflow = 0. The ninth event is absent.
- Assert `reset_n`=0 mid-debounce and with a nonempty FIFO → `readdata`=0, `irq`=0 immediately; after release, all registers read 0.
